hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, is the number of fetch-side bubble cycles after a taken control transfer (legal range 1..7).
REQ-002 Parameter REG_ADDR_WIDTH, default 5, is the register-address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_rs1_addr_i / id_rs2_addr_i  in  REG_ADDR_WIDTH each  source registers of the instruction in ID.
REQ-006 id_uses_rs1_i / id_uses_rs2_i  in  1 each  the ID instruction reads rs1 / rs2.
REQ-007 ex_rd_addr_i, ex_write_en_i, ex_load_i  in  REG_ADDR_WIDTH,1,1  destination, write enable and load flag of the EX instruction.
REQ-008 mem_rd_addr_i, mem_write_en_i  in  REG_ADDR_WIDTH,1  destination and write enable of the MEM instruction.
REQ-009 branch_taken_i  in  1  taken branch, jal or jalr resolved in EX this cycle.
REQ-010 dmem_req_i, dmem_gnt_i  in  1,1  MEM-stage data-memory request and grant.
REQ-011 pc_stall_o, if_id_stall_o, id_ex_stall_o  out  1 each  hold the PC and the IF/ID and ID/EX registers.
REQ-012 if_id_clear_o, id_ex_clear_o  out  1 each  insert a bubble into IF/ID or ID/EX.
REQ-013 fwrd_opA_type1_o, fwrd_opA_type2_o, fwrd_opB_type1_o, fwrd_opB_type2_o  out  1 each  forward-select to ID/EX.
REQ-014 state_o  out  2  current FSM state, for debug.

Function
REQ-015 FSM states: RUN=0, LD_STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-016 Event priority, highest first: mem_wait = dmem_req_i & ~dmem_gnt_i; then branch_taken_i; then load-use hazard.
REQ-017 Load-use hazard = ex_load_i & ex_write_en_i & ex_rd_addr_i != 0 & ((id_uses_rs1_i & rs1 == ex_rd) | (id_uses_rs2_i & rs2 == ex_rd)).
REQ-018 Forwarding is combinational from the inputs.
  - type1 (rd from EX) when ex_write_en_i, ex_rd != 0, ~ex_load_i and the address matches.
  - type2 (rd from MEM) when mem_write_en_i, mem_rd != 0, the address matches and type1 is not set for that operand.
  - Forwarding is forced to 0 whenever id_ex_stall_o = 1.
REQ-019 In any state, mem_wait:
  - pc_stall_o, if_id_stall_o and id_ex_stall_o = 1; clears = 0.
  - Next state MEM_WAIT; remain there until dmem_gnt_i = 1, then return to RUN.
REQ-020 RUN + branch_taken_i (no mem_wait):
  - if_id_clear_o = 1 and id_ex_clear_o = 1 in the same cycle.
  - Flush counter loads FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES > 1, else RUN.
REQ-021 FLUSH: if_id_clear_o = 1 each cycle; the counter decrements; exit to RUN on the cycle the counter reads 0. A branch_taken_i inside FLUSH reloads the counter.
REQ-022 RUN + load-use (no branch, no mem_wait):
  - pc_stall_o = if_id_stall_o = 1, id_ex_clear_o = 1, id_ex_stall_o = 0.
  - Next state LD_STALL.
REQ-023 LD_STALL lasts exactly one cycle with all stalls/clears 0 (the load is now in MEM; type2 forwarding applies), then RUN.
REQ-024 Never assert id_ex_stall_o together with id_ex_clear_o, or if_id_stall_o together with if_id_clear_o.
REQ-025 Outputs are combinational from state plus inputs, so the ID/EX register samples them in the same cycle.

Reset
REQ-026 While rst = 1: state = RUN, counter = 0, all stalls = 0, both clears = 1 (the pipeline fills with bubbles), all fwrd_* = 0.
REQ-027 rst asserted mid-MEM_WAIT or mid-FLUSH aborts the operation; the first cycle after reset is RUN.

Structure
REQ-028 The state enum and the FLUSH_CYCLES default belong in riscv_defines.
REQ-029 A single sub-module, fwd_unit, holds the REQ-018 comparators and is instantiated once.

Verification
REQ-030 Load-use: lw x5 in EX, add x6,x5,x1 in ID -> one cycle of pc/if_id stall + id_ex_clear, then fwrd_opA_type2_o = 1, state RUN.
REQ-031 ALU chain: add x3 in EX and x3 in MEM, ID reads rs2 = x3 -> fwrd_opB_type1_o = 1, fwrd_opB_type2_o = 0; rd = x0 -> no forwarding.
REQ-032 Branch with FLUSH_CYCLES = 2 -> if_id_clear_o high for 2 cycles, id_ex_clear_o for 1 cycle, then RUN.
REQ-033 dmem_req_i = 1, dmem_gnt_i = 0 for 3 cycles while a load-use and a branch are also present -> 3 cycles of full stall, no clears, no forwarding; branch flush on the grant cycle.
REQ-034 rst pulse during FLUSH -> clears = 1 and stalls = 0 during reset, state_o = 0 on the next cycle.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and flush defaults.
package riscv_defines;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } hz_state_e;

   localparam int unsigned FLUSH_CYCLES_DEF = 2;
   localparam int unsigned FLUSH_CNT_W      = 3;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select: EX result wins over MEM result; loads in EX never forward.
module fwd_unit #(
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
   input  logic                      ex_write_en_i,
   input  logic                      ex_load_i,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
   input  logic                      mem_write_en_i,
   input  logic                      en_i,
   output logic                      opA_type1_o,
   output logic                      opA_type2_o,
   output logic                      opB_type1_o,
   output logic                      opB_type2_o
);

   logic ex_src_ok, mem_src_ok;

   assign ex_src_ok  = en_i & ex_write_en_i & ~ex_load_i & (ex_rd_addr_i != '0);
   assign mem_src_ok = en_i & mem_write_en_i & (mem_rd_addr_i != '0);

   assign opA_type1_o = ex_src_ok & (rs1_addr_i == ex_rd_addr_i);
   assign opB_type1_o = ex_src_ok & (rs2_addr_i == ex_rd_addr_i);
   assign opA_type2_o = mem_src_ok & (rs1_addr_i == mem_rd_addr_i) & ~opA_type1_o;
   assign opB_type2_o = mem_src_ok & (rs2_addr_i == mem_rd_addr_i) & ~opB_type1_o;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use stalls and forwarding.
module hazard_ctrl import riscv_defines::*; #(
   parameter int unsigned FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
   input  logic                      id_uses_rs1_i,
   input  logic                      id_uses_rs2_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
   input  logic                      ex_write_en_i,
   input  logic                      ex_load_i,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
   input  logic                      mem_write_en_i,
   input  logic                      branch_taken_i,
   input  logic                      dmem_req_i,
   input  logic                      dmem_gnt_i,
   output logic                      pc_stall_o,
   output logic                      if_id_stall_o,
   output logic                      id_ex_stall_o,
   output logic                      if_id_clear_o,
   output logic                      id_ex_clear_o,
   output logic                      fwrd_opA_type1_o,
   output logic                      fwrd_opA_type2_o,
   output logic                      fwrd_opB_type1_o,
   output logic                      fwrd_opB_type2_o,
   output logic [1:0]                state_o
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   hz_state_e              state_q, state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic                   mem_wait, load_use;

   assign mem_wait = dmem_req_i & ~dmem_gnt_i;
   assign load_use = ex_load_i & ex_write_en_i & (ex_rd_addr_i != '0) &
                     ((id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                      (id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));

   // Priority chain; MEM_WAIT falls through to RUN behaviour once the grant arrives.
   always_comb begin
      pc_stall_o    = 1'b0;
      if_id_stall_o = 1'b0;
      id_ex_stall_o = 1'b0;
      if_id_clear_o = 1'b0;
      id_ex_clear_o = 1'b0;
      state_d       = RUN;
      cnt_d         = cnt_q;
      if (rst) begin
         if_id_clear_o = 1'b1;
         id_ex_clear_o = 1'b1;
      end else if (mem_wait) begin
         pc_stall_o    = 1'b1;
         if_id_stall_o = 1'b1;
         id_ex_stall_o = 1'b1;
         state_d       = MEM_WAIT;
         cnt_d         = '0;
      end else if (state_q == LD_STALL) begin
         state_d = RUN;
      end else if (branch_taken_i) begin
         if_id_clear_o = 1'b1;
         id_ex_clear_o = 1'b1;
         cnt_d         = FLUSH_LOAD;
         state_d       = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (state_q == FLUSH) begin
         if_id_clear_o = 1'b1;
         cnt_d         = cnt_q - FLUSH_CNT_W'(1);
         state_d       = (cnt_q <= FLUSH_CNT_W'(1)) ? RUN : FLUSH;
      end else if (load_use) begin
         pc_stall_o    = 1'b1;
         if_id_stall_o = 1'b1;
         id_ex_clear_o = 1'b1;
         state_d       = LD_STALL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;

   fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
      .rs1_addr_i     (id_rs1_addr_i),
      .rs2_addr_i     (id_rs2_addr_i),
      .ex_rd_addr_i   (ex_rd_addr_i),
      .ex_write_en_i  (ex_write_en_i),
      .ex_load_i      (ex_load_i),
      .mem_rd_addr_i  (mem_rd_addr_i),
      .mem_write_en_i (mem_write_en_i),
      .en_i           (~rst & ~id_ex_stall_o),
      .opA_type1_o    (fwrd_opA_type1_o),
      .opA_type2_o    (fwrd_opA_type2_o),
      .opB_type1_o    (fwrd_opB_type1_o),
      .opB_type2_o    (fwrd_opB_type2_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a rule-level hazard model.
module tb_hazard_ctrl;

   localparam int F  = 2;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1, rs2, ex_rd, mem_rd;
   logic          u1, u2, ex_we, ex_ld, mem_we, br, req, gnt;
   logic          pc_stall, ifid_stall, idex_stall, ifid_clr, idex_clr;
   logic          fa1, fa2, fb1, fb2;
   logic [1:0]    state;

   int n_chk  = 0;
   int n_fail = 0;
   int m_st   = 0;   // 0 run, 1 load stall, 2 flushing, 3 waiting on memory
   int m_left = 0;   // flush cycles still owed after the current one

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(F), .REG_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_rd_addr_i(ex_rd), .ex_write_en_i(ex_we), .ex_load_i(ex_ld),
      .mem_rd_addr_i(mem_rd), .mem_write_en_i(mem_we),
      .branch_taken_i(br), .dmem_req_i(req), .dmem_gnt_i(gnt),
      .pc_stall_o(pc_stall), .if_id_stall_o(ifid_stall), .id_ex_stall_o(idex_stall),
      .if_id_clear_o(ifid_clr), .id_ex_clear_o(idex_clr),
      .fwrd_opA_type1_o(fa1), .fwrd_opA_type2_o(fa2),
      .fwrd_opB_type1_o(fb1), .fwrd_opB_type2_o(fb2),
      .state_o(state)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // {type1, type2} for one source operand
   function automatic logic [1:0] fsel(input logic [AW-1:0] a);
      if (ex_we && ex_rd != 0 && !ex_ld && a == ex_rd) return 2'b10;
      if (mem_we && mem_rd != 0 && a == mem_rd)        return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle();
      rst = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; ex_rd = 0; ex_we = 0; ex_ld = 0;
      mem_rd = 0; mem_we = 0; br = 0; req = 0; gnt = 0;
   endtask

   // Inputs are set just after a negedge; check, advance the model, wait for the next negedge.
   task automatic cycle();
      logic       mw, lu;
      logic [2:0] e_stall, e_clr;
      logic [3:0] e_fwd;
      #1;
      mw = req && !gnt;
      lu = ex_ld && ex_we && ex_rd != 0 && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
      e_stall = 3'b000;
      e_clr   = 3'b000;
      if (rst)              e_clr   = 3'b011;
      else if (mw)          e_stall = 3'b111;
      else if (m_st == 1)   ;
      else if (br)          e_clr   = 3'b011;
      else if (m_st == 2)   e_clr   = 3'b010;
      else if (lu) begin    e_stall = 3'b110; e_clr = 3'b001; end
      e_fwd = (rst || e_stall[0]) ? 4'b0 : {fsel(rs1), fsel(rs2)};
      check("stalls", {pc_stall, ifid_stall, idex_stall}, e_stall);
      check("clears", {1'b0, ifid_clr, idex_clr}, e_clr);
      check("fwd", {fa1, fa2, fb1, fb2}, e_fwd);
      if (!rst) check("state", state, m_st);
      if (rst)             begin m_st = 0; m_left = 0; end
      else if (mw)         m_st = 3;
      else if (m_st == 1)  m_st = 0;
      else if (br)         begin m_left = F - 1; m_st = (m_left > 0) ? 2 : 0; end
      else if (m_st == 2)  begin m_left--; m_st = (m_left == 0) ? 0 : 2; end
      else if (lu)         m_st = 1;
      else                 m_st = 0;
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1;
      @(negedge clk);
      #1;
      check("rst_clears", {ifid_clr, idex_clr}, 2'b11);
      check("rst_stalls", {pc_stall, ifid_stall, idex_stall}, 3'b000);
      cycle();
      idle();
      cycle();

      // lw x5 in EX, add x6,x5,x1 in ID
      ex_rd = 5; ex_we = 1; ex_ld = 1; rs1 = 5; rs2 = 1; u1 = 1; u2 = 1;
      #1;
      check("lu_stall", {pc_stall, ifid_stall, idex_stall, idex_clr}, 4'b1101);
      cycle();
      ex_rd = 0; ex_we = 0; ex_ld = 0; mem_rd = 5; mem_we = 1;
      #1;
      check("lu_state", state, 1);
      check("lu_fwdA2", fa2, 1);
      cycle();
      idle();
      #1;
      check("lu_back_run", state, 0);
      cycle();

      // ALU chain on x3, then x0 destinations
      ex_rd = 3; ex_we = 1; mem_rd = 3; mem_we = 1; rs2 = 3; u2 = 1;
      #1;
      check("alu_fwdB", {fb1, fb2}, 2'b10);
      cycle();
      ex_rd = 0; mem_rd = 0; rs2 = 0;
      #1;
      check("x0_nofwd", {fa1, fa2, fb1, fb2}, 4'b0);
      cycle();

      // taken branch
      idle(); br = 1;
      #1;
      check("br_clears", {ifid_clr, idex_clr}, 2'b11);
      cycle();
      br = 0;
      #1;
      check("flush_clears", {ifid_clr, idex_clr}, 2'b10);
      check("flush_state", state, 2);
      cycle();
      #1;
      check("post_flush", {state, ifid_clr, idex_clr}, 4'b0000);
      cycle();

      // memory wait masks load-use, branch and forwarding
      ex_rd = 5; ex_we = 1; ex_ld = 1; rs1 = 5; u1 = 1; rs2 = 1; u2 = 1;
      mem_rd = 1; mem_we = 1; br = 1; req = 1; gnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mw_stall", {pc_stall, ifid_stall, idex_stall, ifid_clr, idex_clr}, 5'b11100);
         check("mw_nofwd", {fa1, fa2, fb1, fb2}, 4'b0);
         cycle();
      end
      gnt = 1;
      #1;
      check("gnt_state", state, 3);
      check("gnt_branch", {pc_stall, ifid_clr, idex_clr}, 3'b011);
      cycle();
      idle();
      cycle();
      cycle();

      // reset during FLUSH and during MEM_WAIT
      br = 1; cycle();
      br = 0; rst = 1;
      #1;
      check("rst_flush", {pc_stall, ifid_stall, idex_stall, ifid_clr, idex_clr}, 5'b00011);
      cycle();
      rst = 0;
      #1;
      check("rst_flush_run", state, 0);
      cycle();
      req = 1; cycle(); cycle();
      rst = 1; cycle();
      idle();
      #1;
      check("rst_mw_run", state, 0);
      cycle();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rst    = ($urandom_range(0, 49) == 0);
         rs1    = AW'($urandom_range(0, 3));
         rs2    = AW'($urandom_range(0, 3));
         u1     = 1'($urandom);
         u2     = 1'($urandom);
         ex_rd  = AW'($urandom_range(0, 3));
         ex_we  = 1'($urandom);
         ex_ld  = 1'($urandom);
         mem_rd = AW'($urandom_range(0, 3));
         mem_we = 1'($urandom);
         br     = ($urandom_range(0, 5) == 0);
         req    = ($urandom_range(0, 3) == 0);
         gnt    = 1'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
